// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment pattern reader: glyph table,
// blank pattern and FSM state encoding.
package seg_pkg;

  // Active-low segment patterns (bit6=g .. bit0=a) indexed by hex value.
  localparam logic [6:0] GLYPHS [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/seg_to_nibble.sv
// Combinational glyph decoder: maps a seven-segment pattern to its hex value.
// Patterns not in the glyph table (blank included) report legal = 0.
module seg_to_nibble
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       legal
);

  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPHS[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_pattern_reader.sv
// Reconstructs hex frames by snooping a multiplexed seven-segment display bus.
// Each digit must be stable for STABLE_CYCLES samples before it is accepted.
module seg_pattern_reader
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic [6:0]              seg_in,
  output logic [4*NUM_DIGITS-1:0] word_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err_pattern,
  output logic                    err_overrun,
  input  logic                    err_clear,
  output state_e                  fsm_state
);

  logic [NUM_DIGITS-1:0]   an_q, an_p;
  logic [6:0]              seg_q, seg_p;
  state_e                  state, state_nx;
  logic [7:0]              cnt, cnt_nx;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] frame;
  logic [3:0]              nibble;
  logic                    legal;
  logic                    sample_valid, same, mask_full, handshake;

  // Current registered sample plus the one before it, for stability compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= '1;
      an_p  <= '1;
      seg_p <= '1;
    end else begin
      an_q  <= an_in;
      seg_q <= seg_in;
      an_p  <= an_q;
      seg_p <= seg_q;
    end
  end

  assign sample_valid = $onehot(~an_q);
  assign same         = (an_q == an_p) && (seg_q == seg_p);

  seg_to_nibble u_dec (
    .seg    (seg_q),
    .nibble (nibble),
    .legal  (legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (sample_valid) begin
          state_nx = COUNT;
          cnt_nx   = 8'd1;
        end
      end
      COUNT: begin
        if (!same) begin
          state_nx = sample_valid ? COUNT : IDLE;
          cnt_nx   = sample_valid ? 8'd1 : 8'd0;
        end else if (cnt == 8'(STABLE_CYCLES - 1)) begin
          state_nx = HOLD;
          cnt_nx   = 8'(STABLE_CYCLES);
          capture  = 1'b1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      HOLD: begin
        // Only a change of sample re-arms counting: one capture per dwell.
        if (!same) begin
          state_nx = sample_valid ? COUNT : IDLE;
          cnt_nx   = sample_valid ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  assign fsm_state = state;
  assign mask_full = &mask;

  // Output handshake: a frame transfers on any edge where out_valid and
  // out_ready are both high; word_out is held stable until then.
  assign handshake = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask        <= '0;
      frame       <= '0;
      word_out    <= '0;
      out_valid   <= 1'b0;
      err_pattern <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && legal && !an_q[i]) begin
          frame[4*i +: 4] <= nibble;
        end
      end
      mask <= (mask_full ? '0 : mask) | ((capture && legal) ? ~an_q : '0);

      if (mask_full) begin
        word_out  <= frame;
        out_valid <= 1'b1;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end

      if (err_clear)             err_pattern <= 1'b0;
      else if (capture && !legal) err_pattern <= 1'b1;

      if (err_clear)                                   err_overrun <= 1'b0;
      else if (mask_full && out_valid && !out_ready)   err_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Directed bench for seg_pattern_reader: drives a multiplexed display bus
// and checks reconstructed frames and error flags against hand-derived values.
module tb_seg_pattern_reader;
  import seg_pkg::*;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                         G9 = 7'b0011000, GA = 7'b0001000, GB = 7'b0000011,
                         GC = 7'b1000110, GD = 7'b0100001, GF = 7'b0001110;

  logic        clk;
  logic        rst_n;
  logic [3:0]  an_in;
  logic [6:0]  seg_in;
  logic [15:0] word_out;
  logic        out_valid;
  logic        out_ready;
  logic        err_pattern;
  logic        err_overrun;
  logic        err_clear;
  state_e      fsm_state;

  int          checks = 0;
  int          errors = 0;
  int          vld_cnt = 0;
  logic [15:0] last_word = '0;

  seg_pattern_reader #(.STABLE_CYCLES(4), .NUM_DIGITS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_in       (an_in),
    .seg_in      (seg_in),
    .word_out    (word_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_pattern (err_pattern),
    .err_overrun (err_overrun),
    .err_clear   (err_clear),
    .fsm_state   (fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame monitor: with out_ready high each valid cycle is one delivered frame
  always @(negedge clk) begin
    if (out_valid) begin
      vld_cnt   = vld_cnt + 1;
      last_word = word_out;
    end
  end

  // Driver tasks (called at a negedge)
  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic digit(input int idx, input logic [6:0] seg, input int n);
    logic [3:0] a;
    a = 4'b0001 << idx;
    hold(~a, seg, n);
  endtask

  task automatic blank(input int n);
    hold(4'hF, SEG_BLANK, n);
  endtask

  task automatic scan4(input logic [6:0] g0, input logic [6:0] g1,
                       input logic [6:0] g2, input logic [6:0] g3);
    digit(0, g0, 6);
    digit(1, g1, 6);
    digit(2, g2, 6);
    digit(3, g3, 6);
    blank(4);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0; an_in = 4'hF; seg_in = SEG_BLANK; out_ready = 1'b1; err_clear = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, IDLE); end
    checks++; if (word_out !== 16'h0000) begin errors++; $display("FAIL reset_word got=%h exp=0000", word_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (err_pattern !== 1'b0 || err_overrun !== 1'b0) begin
      errors++; $display("FAIL reset_errs got=%b%b exp=00", err_pattern, err_overrun); end
    rst_n = 1'b1;
    blank(2);
  endtask

  task automatic test_basic_frame();
    int snap;
    snap = vld_cnt;
    scan4(G1, G2, G3, G4);
    checks++; if (vld_cnt - snap !== 1) begin errors++; $display("FAIL basic_pulses got=%0d exp=1", vld_cnt - snap); end
    checks++; if (last_word !== 16'h4321) begin errors++; $display("FAIL basic_word got=%h exp=4321", last_word); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
    checks++; if (err_pattern !== 1'b0 || err_overrun !== 1'b0) begin
      errors++; $display("FAIL basic_errs got=%b%b exp=00", err_pattern, err_overrun); end
  endtask

  task automatic test_short_dwell();
    int snap;
    snap = vld_cnt;
    digit(0, G2, 3);
    digit(0, G1, 6);
    digit(1, G5, 6);
    digit(2, G6, 6);
    digit(3, G7, 6);
    blank(4);
    checks++; if (vld_cnt - snap !== 1) begin errors++; $display("FAIL short_pulses got=%0d exp=1", vld_cnt - snap); end
    checks++; if (last_word !== 16'h7651) begin errors++; $display("FAIL short_word got=%h exp=7651", last_word); end
    checks++; if (err_pattern !== 1'b0) begin errors++; $display("FAIL short_errpat got=%b exp=0", err_pattern); end
  endtask

  task automatic test_blank_glyph();
    int snap;
    snap = vld_cnt;
    digit(2, SEG_BLANK, 8);
    checks++; if (err_pattern !== 1'b1) begin errors++; $display("FAIL blank_errpat got=%b exp=1", err_pattern); end
    checks++; if (fsm_state !== HOLD) begin errors++; $display("FAIL blank_state got=%0d exp=%0d", fsm_state, HOLD); end
    blank(4);
    checks++; if (vld_cnt - snap !== 0) begin errors++; $display("FAIL blank_noframe got=%0d exp=0", vld_cnt - snap); end
    pulse_clear();
    checks++; if (err_pattern !== 1'b0) begin errors++; $display("FAIL blank_clear got=%b exp=0", err_pattern); end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    scan4(GD, GC, GB, GA);
    checks++; if (out_valid !== 1'b1 || word_out !== 16'hABCD) begin
      errors++; $display("FAIL ovr_first got=%b/%h exp=1/abcd", out_valid, word_out); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got=%b exp=0", err_overrun); end
    scan4(GF, G0, GF, G0);
    checks++; if (word_out !== 16'h0F0F) begin errors++; $display("FAIL ovr_word got=%h exp=0f0f", word_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got=%b exp=1", out_valid); end
    checks++; if (err_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", err_overrun); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_handshake got=%b exp=0", out_valid); end
    pulse_clear();
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", err_overrun); end
  endtask

  task automatic test_reset_mid_frame();
    int snap;
    digit(0, G9, 6);
    digit(1, G9, 6);
    rst_n = 1'b0; an_in = 4'hF; seg_in = SEG_BLANK;
    @(negedge clk);
    checks++; if (fsm_state !== IDLE || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state got=%0d/%b exp=%0d/0", fsm_state, out_valid, IDLE); end
    rst_n = 1'b1;
    blank(2);
    snap = vld_cnt;
    digit(2, G7, 6);
    digit(3, G8, 6);
    blank(4);
    checks++; if (vld_cnt - snap !== 0) begin errors++; $display("FAIL rst_stale got=%0d exp=0", vld_cnt - snap); end
    digit(0, G5, 6);
    digit(1, G6, 6);
    blank(4);
    checks++; if (vld_cnt - snap !== 1) begin errors++; $display("FAIL rst_pulses got=%0d exp=1", vld_cnt - snap); end
    checks++; if (last_word !== 16'h8765) begin errors++; $display("FAIL rst_word got=%h exp=8765", last_word); end
  endtask

  task automatic test_multi_select();
    an_in = 4'b1100; seg_in = G1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL multi_idle[%0d] got=%0d exp=%0d", i, fsm_state, IDLE); end
    end
    blank(2);
    checks++; if (out_valid !== 1'b0 || err_pattern !== 1'b0) begin
      errors++; $display("FAIL multi_nocapture got=%b%b exp=00", out_valid, err_pattern); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_short_dwell();
    test_blank_glyph();
    test_overrun();
    test_reset_mid_frame();
    test_multi_select();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_pattern_reader.md
SEG_PATTERN_READER -- requirements
Module: seg_pattern_reader

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical samples required before a digit is accepted (legal range 2..255).
REQ-002 The block SHALL have parameter NUM_DIGITS, default 4, meaning the number of multiplexed digit positions per frame.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port an_in, input, NUM_DIGITS bits: active-low digit enables; bit i low selects digit i.
REQ-006 Port seg_in, input, 7 bits: active-low segments, bit6=g through bit0=a.
REQ-007 Port word_out, output, 4*NUM_DIGITS bits: decoded frame; digit i occupies bits [4i+3:4i].
REQ-008 Port out_valid, output, 1 bit: word_out holds an unconsumed frame.
REQ-009 Port out_ready, input, 1 bit: consumer accepts word_out when out_valid and out_ready are both high at a clock edge.
REQ-010 Port err_pattern, output, 1 bit: sticky flag set when a stable pattern is not a legal hex glyph.
REQ-011 Port err_overrun, output, 1 bit: sticky flag set when a frame completes while out_valid is still high.
REQ-012 Port err_clear, input, 1 bit: synchronous clear of both sticky error flags.

Function
REQ-013 an_in and seg_in SHALL be registered once; all further logic SHALL use only the registered samples.
REQ-014 A registered sample SHALL be valid only when exactly one an_in bit is low; all-high or multiple-low samples SHALL be invalid.
REQ-015 The FSM SHALL have states IDLE, COUNT and HOLD.
REQ-016 IDLE: on a valid sample, go to COUNT with stability counter = 1; otherwise remain in IDLE.
REQ-017 COUNT: if the sample equals the previous sample, increment the counter; if it differs and is valid, restart at 1; if it is invalid, return to IDLE.
REQ-018 COUNT: on the edge where the counter reaches STABLE_CYCLES, capture the digit and go to HOLD.
REQ-019 Capture: the pattern SHALL be looked up in the table 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 A legal pattern SHALL write its nibble to the frame slot of the selected digit and set that digit's bit in the capture mask.
REQ-021 An illegal pattern, including blank 1111111, SHALL set err_pattern and SHALL leave the slot and mask unchanged.
REQ-022 HOLD: stay while the sample is unchanged; on any change, go to COUNT (valid sample, counter = 1) or IDLE (invalid sample), so each digit is captured at most once per dwell.
REQ-023 Recapturing a digit already in the mask SHALL overwrite its slot.
REQ-024 When the mask becomes all ones, on the next edge the frame SHALL be copied to word_out, out_valid SHALL be set, and the mask SHALL be cleared.
REQ-025 out_valid SHALL stay high and word_out SHALL stay stable until an out_ready handshake; on that handshake out_valid SHALL clear on the same edge.
REQ-026 If a frame completes while out_valid is high and no handshake occurs on that edge, word_out SHALL be overwritten, out_valid SHALL stay high, and err_overrun SHALL be set.
REQ-027 If a frame completes on the same edge as a handshake, the new frame SHALL load, out_valid SHALL stay high, and no overrun SHALL be flagged.
REQ-028 err_clear SHALL take priority over a simultaneous set of either error flag.
REQ-029 Latency SHALL be 1 (input register) + STABLE_CYCLES edges from a stable input to digit capture, plus 1 edge to out_valid for the completing digit.

Reset
REQ-030 When rst_n is low, the block SHALL asynchronously force FSM=IDLE, counter=0, mask=0, frame slots=0, registered samples to all-ones, word_out=0, out_valid=0, err_pattern=0 and err_overrun=0.
REQ-031 Reset asserted mid-frame SHALL discard all partial captures; the first frame after reset SHALL need all NUM_DIGITS digits captured afresh.

Structure
REQ-032 Package seg_pkg SHALL hold the 16-entry glyph table, the blank constant 7'b1111111, and the FSM state enum.
REQ-033 The glyph-to-nibble lookup SHALL be a combinational sub-module seg_to_nibble, with outputs nibble[3:0] and legal.

Verification
REQ-034 Scan digits 0..3 with glyphs 1,2,3,4, each held 6 cycles, out_ready=1 -> one out_valid pulse, word_out=16'h4321, no error flags.
REQ-035 Digit 0 holds 0100100 for only 3 cycles and then 1111001 for 6 cycles -> slot 0 = 1, err_pattern stays 0.
REQ-036 Digit 2 holds 1111111 (blank) for 8 cycles -> err_pattern=1, no frame completes; err_clear pulse -> err_pattern=0.
REQ-037 out_ready=0, two full frames 16'hABCD then 16'h0F0F -> word_out=16'h0F0F, out_valid=1, err_overrun=1.
REQ-038 rst_n pulsed low after 2 of 4 digits are captured, then scan a full frame 16'h8765 -> word_out=16'h8765, with no stale digits from before reset.
REQ-039 an_in=4'b1100 for 10 cycles -> no capture, FSM stays in IDLE.
